// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Brief    : Shared types and constants for the I/D memory-port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick2
//  Brief    : Two-way winner select, round-robin or D-first on a tie.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic req_inst,
    input  logic req_data,
    input  logic last_grant,
    input  logic d_priority,
    output logic any_req,
    output logic winner
);

    assign any_req = req_inst | req_data;

    always_comb begin
        winner = OWNER_I;
        if (req_data && !req_inst) begin
            winner = OWNER_D;
        end else if (req_data && req_inst) begin
            // On a tie the port that did not win last time goes next
            winner = d_priority ? OWNER_D : ~last_grant;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares one 256-bit memory port between I-cache and D-cache.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DCACHE_PRIORITY = 0,
    parameter int TIMEOUT         = 1023,
    parameter int CNT_W           = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_enable_i,
    input  logic              i_write_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    input  logic [LINE_W-1:0] i_data_i,
    output logic              i_ack_o,
    output logic [LINE_W-1:0] i_data_o,
    input  logic              d_enable_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [LINE_W-1:0] d_data_i,
    output logic              d_ack_o,
    output logic [LINE_W-1:0] d_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              owner_o,
    output logic [CNT_W-1:0]  i_grants_o,
    output logic [CNT_W-1:0]  d_grants_o,
    output logic              timeout_o
);

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] c_wait_limit = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  c_cnt_max    = '1;
    localparam logic              c_d_priority = (DCACHE_PRIORITY != 0);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_mem_enable;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LINE_W-1:0] r_mem_data;
    logic              r_owner;
    logic [CNT_W-1:0]  r_i_grants;
    logic [CNT_W-1:0]  r_d_grants;
    logic [WAIT_W-1:0] r_wait;
    logic              r_timeout;

    logic w_any_req;
    logic w_winner;
    logic w_grant;
    logic w_ack;
    logic w_wait_tick;

    rr_pick2 u_pick (
        .req_inst   (i_enable_i),
        .req_data   (d_enable_i),
        .last_grant (r_owner),
        .d_priority (c_d_priority),
        .any_req    (w_any_req),
        .winner     (w_winner)
    );

    // Requests are only looked at in IDLE, so a stale enable in RELEASE is dropped
    assign w_grant     = (r_state == IDLE) && w_any_req;
    assign w_ack       = (r_state == BUSY) && mem_ack_i;
    assign w_wait_tick = (r_state == BUSY) && !mem_ack_i;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_any_req) w_state_next = BUSY;
            BUSY:    if (mem_ack_i) w_state_next = RELEASE;
            RELEASE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= IDLE;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_owner      <= OWNER_I;
            r_i_grants   <= '0;
            r_d_grants   <= '0;
            r_wait       <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_mem_enable <= 1'b1;
                r_owner      <= w_winner;
                if (w_winner == OWNER_D) begin
                    r_mem_write <= d_write_i;
                    r_mem_addr  <= d_addr_i;
                    r_mem_data  <= d_data_i;
                    if (r_d_grants != c_cnt_max) r_d_grants <= r_d_grants + 1'b1;
                end else begin
                    r_mem_write <= i_write_i;
                    r_mem_addr  <= i_addr_i;
                    r_mem_data  <= i_data_i;
                    if (r_i_grants != c_cnt_max) r_i_grants <= r_i_grants + 1'b1;
                end
            end
            if (w_ack) begin
                r_mem_enable <= 1'b0;
                r_wait       <= '0;
            end
            // Wait count stops at the limit; the flag is sticky until reset
            if (w_wait_tick && (TIMEOUT != 0)) begin
                if (r_wait != c_wait_limit) r_wait <= r_wait + 1'b1;
                if (r_wait == c_wait_limit - 1'b1) r_timeout <= 1'b1;
            end
        end
    end

    assign mem_enable_o = r_mem_enable;
    assign mem_write_o  = r_mem_write;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;
    assign owner_o      = r_owner;
    assign i_grants_o   = r_i_grants;
    assign d_grants_o   = r_d_grants;
    assign timeout_o    = r_timeout;

    assign i_ack_o  = w_ack && (r_owner == OWNER_I);
    assign d_ack_o  = w_ack && (r_owner == OWNER_D);
    assign i_data_o = i_ack_o ? mem_data_i : '0;
    assign d_data_o = d_ack_o ? mem_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Round-robin and D-priority arbiters checked against a cycle model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int TO = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         ien [2], iwr [2], den [2], dwr [2], mack [2];
    logic [31:0]  iad [2], dad [2];
    logic [255:0] idt [2], ddt [2], mdt [2];
    logic         iack [2], dack [2], men [2], mwr [2], own [2], tmo [2];
    logic [255:0] ido [2], ddo [2], mdo [2];
    logic [31:0]  mad [2];
    logic [CW-1:0] igr [2], dgr [2];

    // Instance 0 is round-robin, instance 1 gives D fixed priority
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.DCACHE_PRIORITY(g), .TIMEOUT(TO), .CNT_W(CW)) u_dut (
            .clk_i(clk), .rst_i(rst_n),
            .i_enable_i(ien[g]), .i_write_i(iwr[g]), .i_addr_i(iad[g]), .i_data_i(idt[g]),
            .i_ack_o(iack[g]), .i_data_o(ido[g]),
            .d_enable_i(den[g]), .d_write_i(dwr[g]), .d_addr_i(dad[g]), .d_data_i(ddt[g]),
            .d_ack_o(dack[g]), .d_data_o(ddo[g]),
            .mem_enable_o(men[g]), .mem_write_o(mwr[g]), .mem_addr_o(mad[g]), .mem_data_o(mdo[g]),
            .mem_ack_i(mack[g]), .mem_data_i(mdt[g]),
            .owner_o(own[g]), .i_grants_o(igr[g]), .d_grants_o(dgr[g]), .timeout_o(tmo[g])
        );
    end

    int n_checks;
    int n_fail;

    // Reference model: transaction in flight, cooldown cycles, last winner
    bit           m_busy [2];
    int           m_cool [2];
    bit           m_own  [2];
    int           m_icnt [2], m_dcnt [2], m_wait [2];
    bit           m_to   [2];
    bit           m_wr   [2];
    logic [31:0]  m_ad   [2];
    logic [255:0] m_dt   [2];

    bit last_ia [2], last_da [2], post_i [2], post_d [2];
    int lat [2];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_cool[k] = 0; m_own[k] = 0;
            m_icnt[k] = 0; m_dcnt[k] = 0; m_wait[k] = 0; m_to[k] = 0;
            m_wr[k] = 0; m_ad[k] = '0; m_dt[k] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (m_busy[k]) begin
                if (mack[k]) begin
                    m_busy[k] = 0; m_cool[k] = 1; m_wait[k] = 0;
                end else begin
                    m_wait[k]++;
                    if (m_wait[k] >= TO) m_to[k] = 1;
                end
            end else if (m_cool[k] > 0) begin
                m_cool[k]--;
            end else if (ien[k] || den[k]) begin
                bit pick_d;
                if (ien[k] && den[k]) pick_d = (k == 1) ? 1'b1 : (m_own[k] == 1'b0);
                else                  pick_d = den[k];
                m_busy[k] = 1;
                m_own[k]  = pick_d;
                if (pick_d) begin
                    m_wr[k] = dwr[k]; m_ad[k] = dad[k]; m_dt[k] = ddt[k];
                    if (m_dcnt[k] < 65535) m_dcnt[k]++;
                end else begin
                    m_wr[k] = iwr[k]; m_ad[k] = iad[k]; m_dt[k] = idt[k];
                    if (m_icnt[k] < 65535) m_icnt[k]++;
                end
            end
        end
    endtask

    task automatic cmp_model();
        for (int k = 0; k < 2; k++) begin
            bit ea_i, ea_d;
            ea_i = m_busy[k] && mack[k] && !m_own[k];
            ea_d = m_busy[k] && mack[k] && m_own[k];
            chk($sformatf("m%0d.enable", k), men[k], m_busy[k]);
            if (m_busy[k]) begin
                chk($sformatf("m%0d.write", k), mwr[k], m_wr[k]);
                chk($sformatf("m%0d.addr", k), mad[k], m_ad[k]);
                chk($sformatf("m%0d.wdata", k), mdo[k], m_dt[k]);
            end
            chk($sformatf("m%0d.owner", k), own[k], m_own[k]);
            chk($sformatf("m%0d.i_grants", k), igr[k], m_icnt[k]);
            chk($sformatf("m%0d.d_grants", k), dgr[k], m_dcnt[k]);
            chk($sformatf("m%0d.timeout", k), tmo[k], m_to[k]);
            chk($sformatf("m%0d.i_ack", k), iack[k], ea_i);
            chk($sformatf("m%0d.d_ack", k), dack[k], ea_d);
            chk($sformatf("m%0d.i_data", k), ido[k], ea_i ? mdt[k] : 256'h0);
            chk($sformatf("m%0d.d_data", k), ddo[k], ea_d ? mdt[k] : 256'h0);
        end
    endtask

    // Compare mid-cycle, advance the model on the edge, drive inputs 1 after it
    task automatic tick();
        @(negedge clk);
        cmp_model();
        for (int k = 0; k < 2; k++) begin
            last_ia[k] = iack[k];
            last_da[k] = dack[k];
        end
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom();
        a[4:0] = 5'd0;
        return a;
    endfunction

    task automatic agent(input bit acked, input bit en, input bit post, input int pct,
                         input bit cont, output bit en_n, output bit post_n, output bit raise);
        en_n = en; post_n = 0; raise = 0;
        if (acked) begin
            post_n = !cont;
            raise  = cont;
        end else if (post) begin
            en_n = 0;
            if ($urandom_range(0, 99) < pct / 2) begin en_n = 1; raise = 1; end
        end else if (!en) begin
            if ($urandom_range(0, 99) < pct) begin en_n = 1; raise = 1; end
        end else if (!cont && $urandom_range(0, 99) < 2) begin
            en_n = 0;
        end
    endtask

    task automatic rand_drive(input int pct, input bit cont);
        for (int k = 0; k < 2; k++) begin
            bit e, p, r;
            agent(last_ia[k], ien[k], post_i[k], pct, cont, e, p, r);
            ien[k] = e; post_i[k] = p;
            if (r) begin iwr[k] = $urandom_range(0, 1); iad[k] = rnd_addr(); idt[k] = rnd256(); end
            agent(last_da[k], den[k], post_d[k], pct, cont, e, p, r);
            den[k] = e; post_d[k] = p;
            if (r) begin dwr[k] = $urandom_range(0, 1); dad[k] = rnd_addr(); ddt[k] = rnd256(); end
            if (men[k]) begin
                if (lat[k] < 0) lat[k] = ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 4);
                if (lat[k] == 0) begin
                    mack[k] = 1; mdt[k] = rnd256(); lat[k] = -2;
                end else begin
                    mack[k] = 0;
                    if (lat[k] > 0) lat[k]--;
                end
            end else begin
                lat[k] = -1;
                mack[k] = ($urandom_range(0, 9) == 0);
                mdt[k] = rnd256();
            end
        end
    endtask

    initial begin
        logic [255:0] a5;
        n_checks = 0;
        n_fail   = 0;
        a5 = {32{8'hA5}};
        for (int k = 0; k < 2; k++) begin
            ien[k] = 0; iwr[k] = 0; iad[k] = '0; idt[k] = '0;
            den[k] = 0; dwr[k] = 0; dad[k] = '0; ddt[k] = '0;
            mack[k] = 0; mdt[k] = '0;
            post_i[k] = 0; post_d[k] = 0; lat[k] = -1;
            last_ia[k] = 0; last_da[k] = 0;
        end
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("reset.enable", men[k], 0);
            chk("reset.owner", own[k], 0);
            chk("reset.i_grants", igr[k], 0);
            chk("reset.d_grants", dgr[k], 0);
            chk("reset.timeout", tmo[k], 0);
        end
        tick();

        // Single D read, then stale enable through RELEASE
        dad[0] = 32'h0000_0400; dwr[0] = 0; den[0] = 1;
        tick();
        chk("rd.enable", men[0], 1);
        chk("rd.addr", mad[0], 32'h400);
        chk("rd.write", mwr[0], 0);
        chk("rd.owner", own[0], 1);
        chk("rd.d_grants", dgr[0], 1);
        repeat (9) tick();
        mdt[0] = a5; mack[0] = 1;
        #1;
        chk("rd.d_ack", dack[0], 1);
        chk("rd.d_data", ddo[0], a5);
        chk("rd.i_ack", iack[0], 0);
        chk("rd.i_data", ido[0], 0);
        tick();
        mack[0] = 0;
        chk("rd.enable_fall", men[0], 0);
        tick();
        den[0] = 0;
        chk("stale.release", men[0], 0);
        tick();
        chk("stale.idle", men[0], 0);
        chk("stale.d_grants", dgr[0], 1);

        // D write, then reset while it is in flight
        den[0] = 1; dwr[0] = 1; dad[0] = 32'h0000_0440; ddt[0] = rnd256();
        tick();
        chk("wr.d_grants", dgr[0], 2);
        chk("wr.write", mwr[0], 1);
        tick();
        chk("rst.pre_busy", men[0], 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.enable", men[0], 0);
        chk("rst.owner", own[0], 0);
        chk("rst.d_grants", dgr[0], 0);
        chk("rst.i_grants", igr[0], 0);
        chk("rst.timeout", tmo[0], 0);
        den[0] = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Round-robin tie from reset: D, I, D, I with a 2-cycle gap after each ack
        ien[0] = 1; iwr[0] = 0; iad[0] = 32'h100;
        den[0] = 1; dwr[0] = 1; dad[0] = 32'h200; ddt[0] = rnd256();
        tick();
        for (int n = 0; n < 4; n++) begin
            bit exp_d;
            exp_d = (n % 2 == 0);
            chk($sformatf("rr.owner%0d", n), own[0], exp_d);
            chk($sformatf("rr.addr%0d", n), mad[0], exp_d ? 32'h200 : 32'h100);
            repeat (2) tick();
            mdt[0] = rnd256(); mack[0] = 1;
            tick();
            mack[0] = 0;
            tick();
            if (exp_d) den[0] = 0; else ien[0] = 0;
            chk($sformatf("rr.gap%0d", n), men[0], 0);
            tick();
            chk($sformatf("rr.regrant%0d", n), men[0], 1);
            ien[0] = 1; den[0] = 1;
        end
        chk("rr.i_grants", igr[0], 2);
        chk("rr.d_grants", dgr[0], 3);
        ien[0] = 0; den[0] = 0;
        tick();
        mack[0] = 1;
        tick();
        mack[0] = 0;
        repeat (3) tick();

        // Fixed priority: both ports held high, D always wins
        ien[1] = 1; iad[1] = 32'h300; den[1] = 1; dad[1] = 32'h380;
        tick();
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("fp.owner%0d", n), own[1], 1);
            tick();
            mack[1] = 1; mdt[1] = rnd256();
            tick();
            mack[1] = 0;
            tick();
            chk($sformatf("fp.gap%0d", n), men[1], 0);
            tick();
        end
        chk("fp.i_grants", igr[1], 0);
        chk("fp.d_grants", dgr[1], 4);
        ien[1] = 0; den[1] = 0;
        mack[1] = 1;
        tick();
        mack[1] = 0;
        repeat (3) tick();

        // Timeout: I granted, ack withheld for more than TO busy cycles
        ien[0] = 1; iwr[0] = 0; iad[0] = 32'h0000_0800;
        tick();
        chk("to.owner", own[0], 0);
        chk("to.enable", men[0], 1);
        repeat (TO - 1) tick();
        chk("to.before", tmo[0], 0);
        tick();
        chk("to.after", tmo[0], 1);
        repeat (3) tick();
        mdt[0] = a5; mack[0] = 1;
        #1;
        chk("to.i_ack", iack[0], 1);
        chk("to.i_data", ido[0], a5);
        tick();
        mack[0] = 0;
        tick();
        ien[0] = 0;
        repeat (2) tick();
        chk("to.sticky", tmo[0], 1);
        chk("to.idle", men[0], 0);

        // Randomized traffic on both instances
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 1000; c++) begin
                case (p)
                    0:       rand_drive(30, 1'b0);
                    1:       rand_drive(100, 1'b1);
                    default: rand_drive(60, 1'b0);
                endcase
                tick();
            end
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
